// File: rtl/psx_host_poller.sv
// Host-side poll sequencer for a PlayStation digital pad port.
// Periodically clocks a 5-byte poll frame, handshakes on ack, and publishes validated button state.
module psx_host_poller #(
  parameter int unsigned CLK_DIV     = 25,
  parameter int unsigned ATT_SETUP   = 25,
  parameter int unsigned ACK_TIMEOUT = 200,
  parameter int unsigned POLL_PERIOD = 833333
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        psx_data,
  input  logic        psx_ack,
  output logic        psx_clk,
  output logic        psx_cmd,
  output logic        psx_att,
  output logic [15:0] buttons,
  output logic [7:0]  pad_id,
  output logic        valid,
  output logic        error,
  output logic        present,
  output logic        busy
);
  localparam int unsigned MAX_AB  = (CLK_DIV > ATT_SETUP) ? CLK_DIV : ATT_SETUP;
  localparam int unsigned MAX_CNT = (MAX_AB > ACK_TIMEOUT) ? MAX_AB : ACK_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
  localparam int unsigned POLL_W  = $clog2(POLL_PERIOD + 1);
  localparam logic [2:0]  LAST_BYTE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LOW, S_HIGH, S_ACKWAIT, S_ACKHOLD, S_FINISH
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [POLL_W-1:0] poll_q, poll_d;
  logic [2:0]        bit_q, bit_d, byte_q, byte_d;
  logic [7:0]        shift_q, shift_d, rx1_q, rx1_d, rx2_q, rx2_d, rx3_q, rx3_d;
  logic              clk_q, clk_d, cmd_q, cmd_d, att_q, att_d, busy_q, busy_d;
  logic              valid_q, valid_d, error_q, error_d, present_q, present_d;
  logic [15:0]       buttons_q, buttons_d;
  logic [7:0]        pad_id_q, pad_id_d;
  logic [1:0]        data_s_q;
  logic [2:0]        ack_s_q;
  logic              poll_wrap, ack_fall, phase_done, setup_done, ack_expired;

  // Poll command bytes 0x01, 0x42, then 0x00 padding.
  function automatic logic cmd_bit(input logic [2:0] byte_idx, input logic [2:0] bit_idx);
    logic [7:0] cmd_byte;
    case (byte_idx)
      3'd0:    cmd_byte = 8'h01;
      3'd1:    cmd_byte = 8'h42;
      default: cmd_byte = 8'h00;
    endcase
    return cmd_byte[bit_idx];
  endfunction

  assign poll_wrap   = (poll_q == POLL_W'(POLL_PERIOD - 1));
  assign ack_fall    = ack_s_q[2] & ~ack_s_q[1];
  assign phase_done  = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign setup_done  = (cnt_q == CNT_W'(ATT_SETUP - 1));
  assign ack_expired = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    poll_d    = poll_wrap ? '0 : poll_q + 1'b1;
    bit_d     = bit_q;
    byte_d    = byte_q;
    shift_d   = shift_q;
    rx1_d     = rx1_q;
    rx2_d     = rx2_q;
    rx3_d     = rx3_q;
    clk_d     = clk_q;
    cmd_d     = cmd_q;
    att_d     = att_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;
    present_d = present_q;
    buttons_d = buttons_q;
    pad_id_d  = pad_id_q;

    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        bit_d  = '0;
        byte_d = '0;
        // A wrap seen outside IDLE is simply lost.
        if (poll_wrap && enable) begin
          state_d = S_SETUP;
          att_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_SETUP: begin
        if (setup_done) begin
          state_d = S_LOW;
          cnt_d   = '0;
          clk_d   = 1'b0;
          cmd_d   = cmd_bit(byte_q, bit_q);
        end
      end
      S_LOW: begin
        if (phase_done) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          clk_d   = 1'b1;
          shift_d = {data_s_q[1], shift_q[7:1]};
        end
      end
      S_HIGH: begin
        if (phase_done) begin
          cnt_d = '0;
          if (bit_q != 3'd7) begin
            state_d = S_LOW;
            bit_d   = bit_q + 3'd1;
            clk_d   = 1'b0;
            cmd_d   = cmd_bit(byte_q, bit_q + 3'd1);
          end else begin
            bit_d = '0;
            case (byte_q)
              3'd1:    rx1_d = shift_q;
              3'd2:    rx2_d = shift_q;
              3'd3:    rx3_d = shift_q;
              default: ;
            endcase
            if (byte_q == LAST_BYTE) begin
              state_d = S_FINISH;
            end else begin
              state_d = S_ACKWAIT;
              byte_d  = byte_q + 3'd1;
            end
          end
        end
      end
      S_ACKWAIT: begin
        if (ack_fall) begin
          state_d = S_ACKHOLD;
          cnt_d   = '0;
        end else if (ack_expired) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          att_d     = 1'b1;
          clk_d     = 1'b1;
          cmd_d     = 1'b1;
          busy_d    = 1'b0;
          error_d   = 1'b1;
          present_d = 1'b0;
        end
      end
      S_ACKHOLD: begin
        if (phase_done) begin
          state_d = S_LOW;
          cnt_d   = '0;
          clk_d   = 1'b0;
          cmd_d   = cmd_bit(byte_q, bit_q);
        end
      end
      S_FINISH: begin
        if (phase_done) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          att_d    = 1'b1;
          cmd_d    = 1'b1;
          busy_d   = 1'b0;
          pad_id_d = rx1_q;
          // Byte 4 is still sitting in the shift register.
          if (rx1_q == 8'h41 && rx2_q == 8'h5A) begin
            buttons_d = {shift_q, rx3_q};
            valid_d   = 1'b1;
            present_d = 1'b1;
          end else begin
            error_d   = 1'b1;
            present_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      poll_q    <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      shift_q   <= '0;
      rx1_q     <= 8'hFF;
      rx2_q     <= 8'hFF;
      rx3_q     <= 8'hFF;
      clk_q     <= 1'b1;
      cmd_q     <= 1'b1;
      att_q     <= 1'b1;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      present_q <= 1'b0;
      buttons_q <= 16'hFFFF;
      pad_id_q  <= 8'hFF;
      data_s_q  <= 2'b11;
      ack_s_q   <= 3'b111;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      poll_q    <= poll_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      shift_q   <= shift_d;
      rx1_q     <= rx1_d;
      rx2_q     <= rx2_d;
      rx3_q     <= rx3_d;
      clk_q     <= clk_d;
      cmd_q     <= cmd_d;
      att_q     <= att_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      present_q <= present_d;
      buttons_q <= buttons_d;
      pad_id_q  <= pad_id_d;
      data_s_q  <= {data_s_q[0], psx_data};
      ack_s_q   <= {ack_s_q[1:0], psx_ack};
    end
  end

  assign psx_clk = clk_q;
  assign psx_cmd = cmd_q;
  assign psx_att = att_q;
  assign busy    = busy_q;
  assign valid   = valid_q;
  assign error   = error_q;
  assign present = present_q;
  assign buttons = buttons_q;
  assign pad_id  = pad_id_q;

endmodule

// File: tb/tb_psx_host_poller.sv
// Directed bench for psx_host_poller: an acking pad model on the main instance,
// a silent pad on a second instance with a short poll period.
module tb_psx_host_poller;
  localparam int unsigned CLK_DIV     = 4;
  localparam int unsigned ATT_SETUP   = 5;
  localparam int unsigned ACK_TIMEOUT = 20;
  localparam int unsigned POLL_PERIOD = 600;
  localparam int unsigned POLL_FAST   = 60;
  localparam int ACK_DLY  = 8;
  localparam int ACK_W    = 3;
  localparam int GOOD_LEN = 373; // 5 + 5*64 + 4*11 + 4 with this pad's ack timing
  localparam int TMO_LEN  = 89;  // 5 + 64 + 20

  logic clk = 1'b0;
  logic rst_n = 1'b0, enable = 1'b0, psx_data = 1'b1, psx_ack = 1'b1;
  logic psx_clk, psx_cmd, psx_att, valid, error, present, busy;
  logic [15:0] buttons;
  logic [7:0]  pad_id;

  logic rst_f_n = 1'b0, enable_f = 1'b1, psx_data_f = 1'b1, psx_ack_f = 1'b1;
  logic psx_clk_f, psx_cmd_f, psx_att_f, valid_f, error_f, present_f, busy_f;
  logic [15:0] buttons_f;
  logic [7:0]  pad_id_f;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] resp [5];
  logic [7:0] cmd_cap [5];
  int   pad_byte = 0, pad_bit = 0, ack_cnt = 0;
  logic clk_prev = 1'b1;
  int   cmd_viol = 0;
  logic att_prev_s = 1'b1, cmd_prev_s = 1'b1, pclk_prev_s = 1'b1;

  always #5 clk = ~clk;

  psx_host_poller #(.CLK_DIV(CLK_DIV), .ATT_SETUP(ATT_SETUP), .ACK_TIMEOUT(ACK_TIMEOUT),
                    .POLL_PERIOD(POLL_PERIOD)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .psx_data(psx_data), .psx_ack(psx_ack),
    .psx_clk(psx_clk), .psx_cmd(psx_cmd), .psx_att(psx_att), .buttons(buttons),
    .pad_id(pad_id), .valid(valid), .error(error), .present(present), .busy(busy));

  psx_host_poller #(.CLK_DIV(CLK_DIV), .ATT_SETUP(ATT_SETUP), .ACK_TIMEOUT(ACK_TIMEOUT),
                    .POLL_PERIOD(POLL_FAST)) u_dut_fast (
    .clk(clk), .rst_n(rst_f_n), .enable(enable_f), .psx_data(psx_data_f), .psx_ack(psx_ack_f),
    .psx_clk(psx_clk_f), .psx_cmd(psx_cmd_f), .psx_att(psx_att_f), .buttons(buttons_f),
    .pad_id(pad_id_f), .valid(valid_f), .error(error_f), .present(present_f), .busy(busy_f));

  // Pad model: shifts resp out on psx_clk falling, records cmd on rising, acks after bytes 0-3.
  always @(negedge clk) begin
    if (!rst_n || psx_att) begin
      pad_byte = 0;
      pad_bit  = 0;
      ack_cnt  = 0;
      psx_data = 1'b1;
      psx_ack  = 1'b1;
    end else begin
      if (ack_cnt > 0) begin
        ack_cnt++;
        psx_ack = !(ack_cnt > ACK_DLY && ack_cnt <= ACK_DLY + ACK_W);
        if (ack_cnt > ACK_DLY + ACK_W) ack_cnt = 0;
      end
      if (clk_prev && !psx_clk && pad_byte < 5) psx_data = resp[pad_byte][pad_bit];
      if (!clk_prev && psx_clk && pad_byte < 5) begin
        cmd_cap[pad_byte][pad_bit] = psx_cmd;
        if (pad_bit == 7) begin
          if (pad_byte < 4) ack_cnt = 1;
          pad_bit = 0;
          pad_byte++;
        end else begin
          pad_bit++;
        end
      end
    end
    clk_prev = psx_clk;
  end

  // cmd may only move together with a psx_clk falling edge while att is low.
  always @(negedge clk) begin
    if (rst_n && !psx_att && !att_prev_s && psx_cmd !== cmd_prev_s && !(pclk_prev_s && !psx_clk))
      cmd_viol++;
    att_prev_s  = psx_att;
    cmd_prev_s  = psx_cmd;
    pclk_prev_s = psx_clk;
  end

  task automatic wait_att(input logic level, input int budget, output int cycles,
                          output int nv, output int ne, output bit ok);
    cycles = 0; nv = 0; ne = 0; ok = 1'b0;
    while (cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (valid) nv++;
      if (error) ne++;
      if (psx_att === level) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_att_f(input logic level, input int budget, output int cycles,
                            output int ne, output bit ok);
    cycles = 0; ne = 0; ok = 1'b0;
    while (cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (error_f) ne++;
      if (psx_att_f === level) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b1;
    resp   = '{8'hFF, 8'h41, 8'h5A, 8'hFE, 8'hFD};
    #23;
    n_checks++;
    if ({psx_att, psx_clk, psx_cmd} !== 3'b111) begin
      n_fail++; $display("FAIL reset_pins: got %b expected 111", {psx_att, psx_clk, psx_cmd});
    end
    n_checks++;
    if (buttons !== 16'hFFFF || pad_id !== 8'hFF) begin
      n_fail++; $display("FAIL reset_data: got %h/%h expected ffff/ff", buttons, pad_id);
    end
    n_checks++;
    if ({valid, error, present, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {valid, error, present, busy});
    end
  endtask

  task automatic test_first_poll();
    int c, nv, ne; bit ok;
    @(negedge clk) rst_n = 1'b1;
    wait_att(1'b0, 700, c, nv, ne, ok);
    n_checks++;
    if (!ok || c != int'(POLL_PERIOD)) begin
      n_fail++; $display("FAIL first_poll_delay: got %0d ok=%0b expected %0d", c, ok, POLL_PERIOD);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_at_att: got %b expected 1", busy);
    end
  endtask

  task automatic test_good_frame();
    int c1, c2, nv1, nv2, ne1, ne2; bit ok1, ok2;
    wait_att(1'b1, 500, c1, nv1, ne1, ok1);
    n_checks++;
    if (!ok1 || c1 != GOOD_LEN) begin
      n_fail++; $display("FAIL good_len: got %0d ok=%0b expected %0d", c1, ok1, GOOD_LEN);
    end
    n_checks++;
    if ({valid, error, busy} !== 3'b100) begin
      n_fail++; $display("FAIL good_pulse: valid/error/busy got %b expected 100", {valid, error, busy});
    end
    n_checks++;
    if (buttons !== 16'hFDFE || pad_id !== 8'h41 || present !== 1'b1) begin
      n_fail++; $display("FAIL good_data: got %h/%h/%b expected fdfe/41/1", buttons, pad_id, present);
    end
    n_checks++;
    if ({cmd_cap[0], cmd_cap[1], cmd_cap[2], cmd_cap[3], cmd_cap[4]} !== 40'h01_42_00_00_00) begin
      n_fail++; $display("FAIL cmd_bytes: got %h %h %h %h %h expected 01 42 00 00 00",
                         cmd_cap[0], cmd_cap[1], cmd_cap[2], cmd_cap[3], cmd_cap[4]);
    end
    n_checks++;
    if (cmd_viol != 0) begin
      n_fail++; $display("FAIL cmd_stable: got %0d changes off psx_clk fall expected 0", cmd_viol);
    end
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++; $display("FAIL valid_width: got %b expected 0", valid);
    end
    wait_att(1'b0, 700, c2, nv2, ne2, ok2);
    n_checks++;
    if (!ok2 || c1 + 1 + c2 != int'(POLL_PERIOD) || nv1 + nv2 != 1) begin
      n_fail++; $display("FAIL poll_period: got %0d valids=%0d expected %0d valids=1",
                         c1 + 1 + c2, nv1 + nv2, POLL_PERIOD);
    end
  endtask

  task automatic test_bad_frame(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] exp_id);
    int c, nv, ne; bit ok;
    resp = '{8'hFF, b1, b2, 8'h12, 8'h34};
    wait_att(1'b1, 500, c, nv, ne, ok);
    n_checks++;
    if (!ok || {valid, error, busy} !== 3'b010) begin
      n_fail++; $display("FAIL bad_pulse: valid/error/busy got %b ok=%0b expected 010", {valid, error, busy}, ok);
    end
    n_checks++;
    if (buttons !== 16'hFDFE || pad_id !== exp_id || present !== 1'b0) begin
      n_fail++; $display("FAIL bad_data: got %h/%h/%b expected fdfe/%h/0", buttons, pad_id, present, exp_id);
    end
    @(negedge clk);
    n_checks++;
    if (error !== 1'b0) begin
      n_fail++; $display("FAIL error_width: got %b expected 0", error);
    end
    wait_att(1'b0, 700, c, nv, ne, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL bad_next_poll: got no att after %0d cycles expected one", c);
    end
  endtask

  task automatic test_enable_drop();
    int c, nv, ne; bit ok;
    resp = '{8'hFF, 8'h41, 8'h5A, 8'hA5, 8'h3C};
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (pad_byte == 2) begin ok = 1'b1; break; end
    end
    repeat (10) @(negedge clk);
    enable = 1'b0;
    wait_att(1'b1, 500, c, nv, ne, ok);
    n_checks++;
    if (!ok || valid !== 1'b1 || buttons !== 16'h3CA5 || present !== 1'b1) begin
      n_fail++; $display("FAIL drop_frame: got ok=%0b valid=%b buttons=%h present=%b expected 1/1/3ca5/1",
                         ok, valid, buttons, present);
    end
    wait_att(1'b0, 1300, c, nv, ne, ok);
    n_checks++;
    if (ok) begin
      n_fail++; $display("FAIL drop_no_poll: got att after %0d cycles expected none", c);
    end
    enable = 1'b1;
    wait_att(1'b0, 700, c, nv, ne, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL reenable_poll: got no att after %0d cycles expected one", c);
    end
  endtask

  task automatic test_reset_mid();
    int c, nv, ne; bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (pad_byte == 3) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL reach_byte3: got pad_byte=%0d expected 3", pad_byte);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({psx_att, psx_clk, psx_cmd, valid, error, present, busy} !== 7'b1110000 ||
        buttons !== 16'hFFFF || pad_id !== 8'hFF) begin
      n_fail++; $display("FAIL async_reset: got %b %h %h expected 1110000 ffff ff",
                         {psx_att, psx_clk, psx_cmd, valid, error, present, busy}, buttons, pad_id);
    end
    @(negedge clk) rst_n = 1'b1;
    wait_att(1'b0, 700, c, nv, ne, ok);
    n_checks++;
    if (!ok || c != int'(POLL_PERIOD)) begin
      n_fail++; $display("FAIL reset_repoll: got %0d ok=%0b expected %0d", c, ok, POLL_PERIOD);
    end
    wait_att(1'b1, 500, c, nv, ne, ok);
    n_checks++;
    if (!ok || c != GOOD_LEN || valid !== 1'b1 || buttons !== 16'h3CA5) begin
      n_fail++; $display("FAIL reset_frame: got len=%0d valid=%b buttons=%h expected %0d/1/3ca5",
                         c, valid, buttons, GOOD_LEN);
    end
  endtask

  task automatic test_timeout();
    int c, ne; bit ok;
    @(negedge clk) rst_f_n = 1'b1;
    wait_att_f(1'b0, 100, c, ne, ok);
    n_checks++;
    if (!ok || c != int'(POLL_FAST)) begin
      n_fail++; $display("FAIL fast_first_poll: got %0d ok=%0b expected %0d", c, ok, POLL_FAST);
    end
    wait_att_f(1'b1, 200, c, ne, ok);
    n_checks++;
    if (!ok || c != TMO_LEN) begin
      n_fail++; $display("FAIL timeout_len: got %0d ok=%0b expected %0d", c, ok, TMO_LEN);
    end
    n_checks++;
    if ({error_f, valid_f, busy_f, present_f, psx_clk_f, psx_cmd_f} !== 6'b100011 ||
        ne != 1) begin
      n_fail++; $display("FAIL timeout_flags: got %b errors=%0d expected 100011 errors=1",
                         {error_f, valid_f, busy_f, present_f, psx_clk_f, psx_cmd_f}, ne);
    end
    n_checks++;
    if (buttons_f !== 16'hFFFF || pad_id_f !== 8'hFF) begin
      n_fail++; $display("FAIL timeout_hold: got %h/%h expected ffff/ff", buttons_f, pad_id_f);
    end
  endtask

  task automatic test_overlap();
    int c_idle, c_busy, ne; bit ok_i, ok_b;
    for (int k = 0; k < 2; k++) begin
      wait_att_f(1'b0, 200, c_idle, ne, ok_i);
      wait_att_f(1'b1, 200, c_busy, ne, ok_b);
      n_checks++;
      if (!ok_i || !ok_b || c_idle != 2 * int'(POLL_FAST) - TMO_LEN || c_busy != TMO_LEN) begin
        n_fail++; $display("FAIL overlap_drop: idle=%0d busy=%0d expected %0d/%0d",
                           c_idle, c_busy, 2 * int'(POLL_FAST) - TMO_LEN, TMO_LEN);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_poll();
    test_good_frame();
    test_bad_frame(8'h41, 8'h5B, 8'h41);
    test_bad_frame(8'h73, 8'h5A, 8'h73);
    test_enable_drop();
    test_reset_mid();
    test_timeout();
    test_overlap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
